// File: rtl/car_id_pkg.sv
// Shared types and helpers for the car ID replay block.
// CAR_ID_PACE_EN adds the GAP state used for paced replay.
package car_id_pkg;

  localparam int ENTRIES  = 20;
  localparam int DIGIT_W  = 20;
  localparam int NIBBLE_W = 4;
  localparam int INDEX_W  = 5;

`ifdef CAR_ID_PACE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN} car_id_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_FIN} car_id_state_e;
`endif

  // Records hold IDs least-significant nibble first; display order is the reverse.
  function automatic logic [DIGIT_W-1:0] nibble_rev(input logic [DIGIT_W-1:0] e);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGIT_W / NIBBLE_W; i++)
      r[i*NIBBLE_W +: NIBBLE_W] = e[(DIGIT_W/NIBBLE_W-1-i)*NIBBLE_W +: NIBBLE_W];
    return r;
  endfunction

endpackage

// File: rtl/car_id_pace_timer.sv
// Load-and-count-down timer; expired is high once CYCLES clocks have passed since load.
// Only instantiated when CAR_ID_PACE_EN is defined.
module car_id_pace_timer #(
  parameter int CYCLES = 6_000_000,
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Loading CYCLES-1 gives exactly CYCLES clocks in the waiting state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clear)         count <= '0;
    else if (load)          count <= CNT_W'(CYCLES - 1);
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/car_id_replay.sv
// Replays a captured record of car IDs one entry at a time over a valid/ready port.
// CAR_ID_PACE_EN inserts PACE_CYCLES idle clocks between entries.
//
// state   | meaning
// IDLE    | waiting for load
// SEND    | digit/index presented, waiting for out_ready
// GAP     | pacing delay between entries (CAR_ID_PACE_EN only)
// FIN     | one-cycle done pulse, then back to IDLE
module car_id_replay
  import car_id_pkg::*;
#(
  parameter int ENTRIES     = car_id_pkg::ENTRIES,
  parameter int DIGIT_W     = car_id_pkg::DIGIT_W,
  parameter int PACE_CYCLES = 6_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [ENTRIES*DIGIT_W-1:0] record,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic [DIGIT_W-1:0]         digit,
  output logic                       digit_valid,
  output logic [INDEX_W-1:0]         index,
  output logic                       busy,
  output logic                       done
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

  car_id_state_e              state, state_nxt;
  logic [INDEX_W-1:0]         index_nxt;
  logic [ENTRIES*DIGIT_W-1:0] shadow;
  logic                       capture;
  logic                       xfer;
  logic                       last;

  assign digit_valid = (state == ST_SEND);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);
  assign xfer        = digit_valid & out_ready;
  assign last        = (index == LAST_IDX);
  assign digit       = nibble_rev(shadow[int'(index)*DIGIT_W +: DIGIT_W]);

`ifdef CAR_ID_PACE_EN
  logic pace_load;
  logic pace_expired;

  assign pace_load = xfer & ~last & ~clear;

  car_id_pace_timer #(
    .CYCLES (PACE_CYCLES)
  ) u_pace_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (pace_load),
    .clear   (clear),
    .expired (pace_expired)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      index  <= '0;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (capture) shadow <= record;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          capture   = 1'b1;
          index_nxt = '0;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (last) begin
            state_nxt = ST_FIN;
          end else begin
            index_nxt = index + 1'b1;
`ifdef CAR_ID_PACE_EN
            state_nxt = ST_GAP;
`else
            state_nxt = ST_SEND;
`endif
          end
        end
      end
`ifdef CAR_ID_PACE_EN
      ST_GAP: begin
        if (pace_expired) state_nxt = ST_SEND;
      end
`endif
      ST_FIN: begin
        index_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        index_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
    // Abort overrides load and any same-cycle transfer.
    if (clear) begin
      capture   = 1'b0;
      index_nxt = '0;
      state_nxt = ST_IDLE;
    end
  end

endmodule

// File: doc/car_id_replay.md
CAR_ID_REPLAY -- requirements
Module: car_id_replay

Interface
REQ-001 Parameter ENTRIES, default 20, number of stored IDs per record.
REQ-002 Parameter DIGIT_W, default 20, bits per ID (5 BCD nibbles).
REQ-003 Parameter PACE_CYCLES, default 6_000_000, idle clocks between entries; used only when CAR_ID_PACE_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load  input  1  start replay of record; sampled in IDLE only.
REQ-007 record  input  ENTRIES*DIGIT_W  packed record; entry k at bits [20k+19:20k], nibble-reversed.
REQ-008 clear  input  1  synchronous abort.
REQ-009 out_ready  input  1  downstream accepts digit.
REQ-010 digit  output  DIGIT_W  restored ID, display order.
REQ-011 digit_valid  output  1  digit/index valid.
REQ-012 index  output  5  entry number of digit, 0..ENTRIES-1.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse after last entry is accepted.

Function
REQ-015 States IDLE, SEND, GAP, FIN; reset state IDLE.
REQ-016 IDLE with load=1, clear=0: record copied to internal shadow register, index<=0, next state SEND.
REQ-017 Shadow register is the only source of digit; record changes after the load cycle have no effect.
REQ-018 digit = entry[index] with nibbles reversed: digit[19:16]=e[3:0], digit[15:12]=e[7:4], digit[11:8]=e[11:8], digit[7:4]=e[15:12], digit[3:0]=e[19:16].
REQ-019 digit_valid=1 only in SEND; digit and index held stable while digit_valid=1 and out_ready=0.
REQ-020 Transfer occurs on a cycle with digit_valid=1 and out_ready=1.
REQ-021 Transfer with index<ENTRIES-1: index increments; next state GAP when pacing is enabled, else SEND (back-to-back, one entry per clock with out_ready held high).
REQ-022 Transfer with index=ENTRIES-1: next state FIN; index not incremented.
REQ-023 FIN: done=1 for exactly one cycle, then IDLE; index returns to 0.
REQ-024 load outside IDLE is ignored; no restart, no queuing.
REQ-025 clear=1 in any state: next state IDLE, index<=0, digit_valid=0 next cycle, no done pulse; clear wins over load and over a same-cycle transfer.
REQ-026 First digit_valid appears one clock after the load cycle.
REQ-027 Latency from load to done with out_ready tied high, no pacing: ENTRIES+1 clocks.

Reset
REQ-028 rst=1: state IDLE, shadow register 0, index 0, digit_valid 0, busy 0, done 0, pace counter 0, asynchronously.
REQ-029 rst asserted mid-replay aborts it without a done pulse; first action after release requires a new load.

Configuration
REQ-030 CAR_ID_PACE_EN defined: GAP state present; after each non-final transfer the block waits exactly PACE_CYCLES clocks with digit_valid=0, busy=1, then returns to SEND.
REQ-031 CAR_ID_PACE_EN undefined: no GAP state, no pace counter, PACE_CYCLES unused; behaviour per REQ-021 back-to-back.

Structure
REQ-032 Shared package car_id_pkg holds ENTRIES, DIGIT_W, NIBBLE_W=4, the state enumeration, and the nibble-reversal function used by both capture and replay sides.
REQ-033 One sub-module, car_id_pace_timer: load-and-count-down counter asserting expiry after PACE_CYCLES; instantiated only under CAR_ID_PACE_EN.

Verification
REQ-034 Reset, then load=1 with entry0=20'h54321, entry19=20'hEDCBA, out_ready=1, no pacing -> digit 20'h12345 index 0 one clock later, 20'hABCDE index 19 at clock 20, done pulse at clock 21.
REQ-035 out_ready=0 for 5 cycles while index=3 -> digit, index, digit_valid unchanged for all 5 cycles; advance to index 4 on the cycle after out_ready rises.
REQ-036 load pulsed again at index 7 with a different record -> ignored; entries 8..19 still from the first record.
REQ-037 clear=1 on a transfer cycle at index 10 -> digit_valid=0 and busy=0 next cycle, index=0, no done pulse ever.
REQ-038 CAR_ID_PACE_EN defined, PACE_CYCLES=4 -> exactly 4 cycles with digit_valid=0 between each accepted entry; done 1 clock after the index 19 transfer.
REQ-039 rst asserted at index 12 -> all outputs 0 immediately (before the next clock edge); a following load replays from index 0.
